apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
APB3 initiator that converts a simple single-outstanding request/response port into APB SETUP/ACCESS transfers. It decodes the target slave from the address and drives one PSEL per slave. It waits on the selected slave's PREADY, then returns read data and error status on a one-cycle response strobe. It sits between the core-side bus adapter and the peripheral APB slave interfaces. Slaves that have no PREADY output have PREADY tied high at integration.

Parameters:
NUM_SLAVES, 2, number of APB slaves; PSEL/PREADY/PSLVERR width; must be 1..16.
SLAVE_BASE_BIT, 12, lowest address bit of the 4-bit slave-index field (slave index = PADDR[SLAVE_BASE_BIT+:4]).
TIMEOUT_CYCLES, 16, number of ACCESS cycles without PREADY before abort; only used with APB_MASTER_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
req  in  1  request valid; held until accepted
req_ready  out  1  high only in IDLE; transfer accepted when req && req_ready
req_addr  in  32  byte address
req_wdata  in  32  write data
req_write  in  1  1 = write, 0 = read
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  read data; 0 for writes
rsp_err  out  1  slave error, decode error or timeout
PADDR  out  32  registered request address
PWDATA  out  32  registered write data
PWRITE  out  1  registered direction
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  ACCESS-phase indicator
PRDATA  in  NUM_SLAVES*32  concatenated slave read data; slave k at [k*32+:32]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low on n_rst.
- Reset state: IDLE. req_ready=1, every other output 0, including PADDR, PWDATA and the internal index/timeout registers.
- Reset asserted mid-transfer aborts immediately. No response is issued.
- State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req, capture addr, wdata, write and idx = addr[SLAVE_BASE_BIT+:4].
  - If idx < NUM_SLAVES, go to SETUP.
  - Otherwise go to RESP with a decode error; no APB activity.
- SETUP: PSEL[idx]=1, PENABLE=0. Always go to ACCESS next cycle.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1.
  - If PREADY[idx]=1: register rsp_rdata (PRDATA slice if read, else 0) and rsp_err=PSLVERR[idx]; go to RESP.
  - If PREADY[idx]=0: stay in ACCESS. PADDR, PWDATA, PWRITE and PSEL are held stable.
- RESP: rsp_valid=1 for exactly one cycle, PSEL=0, PENABLE=0. Go to IDLE.
- Decode-error response: rsp_err=1, rsp_rdata=32'hbad1bad1.
- Latency:
  - Zero-wait transfer: request accepted cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3.
  - Each wait state adds 1 cycle.
  - Decode error: rsp_valid cycle 1.
- Back-to-back: req_ready=0 outside IDLE. A req held high through RESP is accepted in the following IDLE cycle, so the minimum spacing is 4 cycles.
- req, req_addr, req_wdata and req_write are ignored outside IDLE.
- PSEL is never multi-hot. PENABLE is never high without PSEL.
- PSLVERR is sampled only when PREADY[idx] is high.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle with PREADY[idx]=0.
  - When it reaches TIMEOUT_CYCLES-1 with PREADY still low, go to RESP with rsp_err=1 and rsp_rdata=32'hdeadbeef.
  - PREADY arriving on the same cycle as the timeout wins: normal completion.
- Not defined: no counter logic; ACCESS waits for PREADY indefinitely.

Decomposition:
- Package apb_master_pkg:
  - state enum (IDLE/SETUP/ACCESS/RESP)
  - DECERR_DATA=32'hbad1bad1, TIMEOUT_DATA=32'hdeadbeef
  - APB data/address width constants
- Sub-module apb_slave_decoder: combinational; idx from address, valid flag, one-hot select. Reused by future bus-fabric blocks.
- FSM, capture registers and timeout counter stay in apb_master_bridge.

Test Plan:
- Zero-wait write: addr=0x0000_1004, wdata=0xA5A5_5A5A, PREADY tied high -> PSEL=2'b10 with PENABLE=0 in cycle 1, PENABLE=1 in cycle 2, rsp_valid in cycle 3, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x0000_0008, slave0 PRDATA=0x1234_5678 -> PADDR/PSEL stable for 4 ACCESS cycles; rsp_valid in cycle 6 with rdata=0x1234_5678.
- Slave error: read to slave1 with PSLVERR=1 at PREADY -> rsp_err=1, rsp_rdata equals the slave1 PRDATA slice.
- Decode error: addr=0x0000_F000 with NUM_SLAVES=2 -> PSEL never asserts, rsp_valid in cycle 1, rsp_err=1, rdata=0xbad1bad1.
- Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY held low -> rsp_err=1, rdata=0xdeadbeef after 16 ACCESS cycles. Repeat with PREADY rising on cycle 16 -> normal completion.
- Reset during ACCESS with req held high -> all outputs 0 asynchronously, no rsp_valid. After release, req is accepted and completes normally.

Source files
------------

// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge and related bus-fabric blocks.
package apb_master_pkg;

    localparam int APB_ADDR_W  = 32;
    localparam int APB_DATA_W  = 32;
    localparam int SLAVE_IDX_W = 4;

    localparam logic [APB_DATA_W-1:0] DECERR_DATA  = 32'hbad1bad1;
    localparam logic [APB_DATA_W-1:0] TIMEOUT_DATA = 32'hdeadbeef;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apbState_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response port plus APB3 bus bundle; master = bridge side, slave = core/peripheral side.
interface apb_master_bridge_if #(
    parameter int NUM_SLAVES = 2
) ();
    import apb_master_pkg::*;

    logic                             req;
    logic                             req_ready;
    logic [APB_ADDR_W-1:0]            req_addr;
    logic [APB_DATA_W-1:0]            req_wdata;
    logic                             req_write;
    logic                             rsp_valid;
    logic [APB_DATA_W-1:0]            rsp_rdata;
    logic                             rsp_err;

    logic [APB_ADDR_W-1:0]            PADDR;
    logic [APB_DATA_W-1:0]            PWDATA;
    logic                             PWRITE;
    logic [NUM_SLAVES-1:0]            PSEL;
    logic                             PENABLE;
    logic [NUM_SLAVES*APB_DATA_W-1:0] PRDATA;
    logic [NUM_SLAVES-1:0]            PREADY;
    logic [NUM_SLAVES-1:0]            PSLVERR;

    modport master (
        input  req, req_addr, req_wdata, req_write,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req, req_addr, req_wdata, req_write,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_master_bridge_decoder.sv
// Combinational slave decoder: index field, in-range flag and one-hot select from a byte address.
module apb_slave_decoder
    import apb_master_pkg::*;
#(
    parameter int NUM_SLAVES     = 2,
    parameter int SLAVE_BASE_BIT = 12
) (
    input  logic [APB_ADDR_W-1:0]  addr_i,
    output logic [SLAVE_IDX_W-1:0] idx_o,
    output logic                   valid_o,
    output logic [NUM_SLAVES-1:0]  sel_o
);
    logic unusedAddr;

    assign idx_o      = addr_i[SLAVE_BASE_BIT +: SLAVE_IDX_W];
    assign unusedAddr = ^addr_i;

    // An out-of-range index matches no slave, so sel_o stays zero and valid_o falls.
    always_comb begin
        sel_o = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_o == SLAVE_IDX_W'(k)) begin
                sel_o[k] = 1'b1;
            end
        end
    end

    assign valid_o = |sel_o;

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: single-outstanding request port to SETUP/ACCESS transfers.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int NUM_SLAVES     = 2,
    parameter int SLAVE_BASE_BIT = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                 clk,
    input logic                 n_rst,
    apb_master_bridge_if.master bus
);
    apbState_e                state_q, state_d;
    logic [APB_ADDR_W-1:0]    addr_q, addr_d;
    logic [APB_DATA_W-1:0]    wdata_q, wdata_d;
    logic                     write_q, write_d;
    logic [SLAVE_IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_SLAVES-1:0]    sel_q, sel_d;
    logic [APB_DATA_W-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic [SLAVE_IDX_W-1:0]   decIdx;
    logic [NUM_SLAVES-1:0]    decSel;
    logic                     decValid;
    logic                     slvReady;
    logic                     slvErr;
    logic [APB_DATA_W-1:0]    slvRdata;

    apb_slave_decoder #(
        .NUM_SLAVES     (NUM_SLAVES),
        .SLAVE_BASE_BIT (SLAVE_BASE_BIT)
    ) u_decoder (
        .addr_i  (bus.req_addr),
        .idx_o   (decIdx),
        .valid_o (decValid),
        .sel_o   (decSel)
    );

    always_comb begin
        slvReady = 1'b0;
        slvErr   = 1'b0;
        slvRdata = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SLAVE_IDX_W'(k)) begin
                slvReady = bus.PREADY[k];
                slvErr   = bus.PSLVERR[k];
                slvRdata = bus.PRDATA[k*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeoutHit;

    assign timeoutHit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unusedTimeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    idx_d   = decIdx;
                    sel_d   = decSel;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (decValid) begin
                        state_d = SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = RESP;
                        rdata_d = DECERR_DATA;
                        err_d   = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // PREADY is checked before the timeout so a late-but-arriving slave still completes.
                if (slvReady) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : slvRdata;
                    err_d   = slvErr;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeoutHit) begin
                    state_d = RESP;
                    rdata_d = TIMEOUT_DATA;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.PADDR     = addr_q;
    assign bus.PWDATA    = wdata_q;
    assign bus.PWRITE    = write_q;
    assign bus.PSEL      = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    assign bus.PENABLE   = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge; expected responses queued at issue, popped on rsp_valid.
module tb_apb_master_bridge;
    import apb_master_pkg::*;

    localparam int NS = 2;
    localparam int TO = 16;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic          clk   = 1'b0;
    logic          n_rst = 1'b0;
    logic [31:0]   slvData0 = '0;
    logic [31:0]   slvData1 = '0;
    logic [NS-1:0] pready   = '1;
    logic [NS-1:0] pslverr  = '0;
    rsp_t          expQ[$];
    rsp_t          exp;
    int            checks = 0;
    int            errors = 0;

    apb_master_bridge_if #(.NUM_SLAVES(NS)) bus ();

    apb_master_bridge #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASE_BIT (12),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    assign bus.PRDATA  = {slvData1, slvData0};
    assign bus.PREADY  = pready;
    assign bus.PSLVERR = pslverr;

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives a request in the IDLE cycle; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic write, input logic [31:0] expRdata,
                                 input logic expErr, input logic holdReq);
        @(negedge clk);
        bus.req       = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_write = write;
        expQ.push_back('{rdata: expRdata, err: expErr});
        @(negedge clk);
        if (!holdReq) bus.req = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 1", bus.req_ready);
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.PWRITE, bus.PSEL, bus.PENABLE,
             bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: PADDR=%h PWDATA=%h PSEL=%b PENABLE=%b rsp_valid=%b rdata=%h err=%b expected all 0",
                     bus.PADDR, bus.PWDATA, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_zero_wait_write();
        pready = '1;
        applyStimulus(32'h0000_1004, 32'hA5A5_5A5A, 1'b1, 32'h0, 1'b0, 1'b0);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.req_ready} !== {2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zw_setup: PSEL=%b PENABLE=%b ready=%b expected 10/0/0", bus.PSEL, bus.PENABLE, bus.req_ready);
        end
        checks++;
        if ({bus.PADDR, bus.PWDATA, bus.PWRITE} !== {32'h0000_1004, 32'hA5A5_5A5A, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zw_bus: PADDR=%h PWDATA=%h PWRITE=%b expected 00001004/a5a55a5a/1", bus.PADDR, bus.PWDATA, bus.PWRITE);
        end
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE} !== {2'b10, 1'b1}) begin
            errors++;
            $display("[TB] FAIL zw_access: PSEL=%b PENABLE=%b expected 10/1", bus.PSEL, bus.PENABLE);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zw_latency: rsp_valid=%b in cycle 3 expected 1", bus.rsp_valid);
        end else begin
            exp = expQ.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                errors++;
                $display("[TB] FAIL zw_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.rsp_valid, bus.req_ready, bus.PSEL, bus.PENABLE} !== {1'b0, 1'b1, 2'b00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL zw_idle: rsp_valid=%b ready=%b PSEL=%b PENABLE=%b expected 0/1/00/0",
                     bus.rsp_valid, bus.req_ready, bus.PSEL, bus.PENABLE);
        end
    endtask

    task automatic test_wait_read();
        pready   = 2'b10;
        slvData0 = 32'h1234_5678;
        applyStimulus(32'h0000_0008, 32'h0, 1'b0, 32'h1234_5678, 1'b0, 1'b0);
        @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            checks++;
            if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid} !== {2'b01, 1'b1, 32'h8, 1'b0}) begin
                errors++;
                $display("[TB] FAIL wait_hold%0d: PSEL=%b PENABLE=%b PADDR=%h rsp_valid=%b", w, bus.PSEL, bus.PENABLE, bus.PADDR, bus.rsp_valid);
            end
            if (w == 3) pready[0] = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_latency: rsp_valid=%b in cycle 6 expected 1", bus.rsp_valid);
        end else begin
            exp = expQ.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                errors++;
                $display("[TB] FAIL wait_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
            end
        end
        pready = '1;
    endtask

    task automatic test_slave_error();
        pready   = '1;
        pslverr  = 2'b10;
        slvData1 = 32'hCAFE_F00D;
        applyStimulus(32'h0000_1010, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL slverr_latency: rsp_valid=%b expected 1", bus.rsp_valid);
        end else begin
            exp = expQ.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                errors++;
                $display("[TB] FAIL slverr_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
            end
        end
        pready   = 2'b10;
        pslverr  = 2'b01;
        slvData0 = 32'h55AA_00FF;
        applyStimulus(32'h0000_0000, 32'h0, 1'b0, 32'h55AA_00FF, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        pslverr   = '0;
        pready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL errmask_latency: rsp_valid=%b expected 1", bus.rsp_valid);
        end else begin
            exp = expQ.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                errors++;
                $display("[TB] FAIL errmask_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
            end
        end
        pready = '1;
    endtask

    task automatic test_decode_error();
        logic [31:0] addrs[2];
        addrs[0] = 32'h0000_F000;
        addrs[1] = 32'h0000_2000;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(addrs[i], 32'h1111_1111, 1'(i), DECERR_DATA, 1'b1, 1'b0);
            checks++;
            if ({bus.rsp_valid, bus.PSEL, bus.PENABLE} !== {1'b1, 2'b00, 1'b0}) begin
                errors++;
                $display("[TB] FAIL decerr_cycle1_%0d: rsp_valid=%b PSEL=%b PENABLE=%b expected 1/00/0", i, bus.rsp_valid, bus.PSEL, bus.PENABLE);
            end
            if (bus.rsp_valid === 1'b1) begin
                exp = expQ.pop_front();
                checks++;
                if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                    errors++;
                    $display("[TB] FAIL decerr_rsp_%0d: rdata=%h err=%b expected %h/%b", i, bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
                end
            end else begin
                expQ.delete();
            end
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.PSEL} !== {1'b0, 2'b00}) begin
                errors++;
                $display("[TB] FAIL decerr_after_%0d: rsp_valid=%b PSEL=%b expected 0/00", i, bus.rsp_valid, bus.PSEL);
            end
        end
    endtask

    task automatic test_back_to_back();
        pready   = '1;
        slvData0 = 32'h0F0F_0F0F;
        applyStimulus(32'h0000_0004, 32'h0, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b1);
        expQ.push_back('{rdata: 32'h0, err: 1'b0});
        bus.req_addr  = 32'h0000_1008;
        bus.req_wdata = 32'h0000_0077;
        bus.req_write = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({bus.req_ready, bus.PADDR, bus.PWRITE} !== {1'b0, 32'h4, 1'b0}) begin
                errors++;
                $display("[TB] FAIL b2b_busy%0d: ready=%b PADDR=%h PWRITE=%b expected 0/00000004/0", c, bus.req_ready, bus.PADDR, bus.PWRITE);
            end
            if (c == 3) begin
                checks++;
                if (bus.rsp_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_first_latency: rsp_valid=%b expected 1", bus.rsp_valid);
                end else begin
                    exp = expQ.pop_front();
                    checks++;
                    if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                        errors++;
                        $display("[TB] FAIL b2b_first_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== {1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_idle: ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
        bus.req = 1'b0;
        checks++;
        if ({bus.PSEL, bus.PADDR, bus.PWRITE, bus.PWDATA} !== {2'b10, 32'h1008, 1'b1, 32'h77}) begin
            errors++;
            $display("[TB] FAIL b2b_second_setup: PSEL=%b PADDR=%h PWRITE=%b PWDATA=%h", bus.PSEL, bus.PADDR, bus.PWRITE, bus.PWDATA);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_latency: rsp_valid=%b expected 1", bus.rsp_valid);
        end else begin
            exp = expQ.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                errors++;
                $display("[TB] FAIL b2b_second_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
            end
        end
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        logic stuck;
        slvData1 = 32'h2468_ACE0;
        for (int pass = 0; pass < 2; pass++) begin
            pready = 2'b01;
            stuck  = 1'b1;
            if (pass == 0) applyStimulus(32'h0000_1000, 32'h0, 1'b0, TIMEOUT_DATA, 1'b1, 1'b0);
            else           applyStimulus(32'h0000_1000, 32'h0, 1'b0, 32'h2468_ACE0, 1'b0, 1'b0);
            for (int c = 2; c <= 17; c++) begin
                @(negedge clk);
                if (bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0) stuck = 1'b0;
            end
            checks++;
            if (stuck !== 1'b1) begin
                errors++;
                $display("[TB] FAIL timeout_wait%0d: left ACCESS before 16 cycles, got %b expected 1", pass, stuck);
            end
            if (pass == 1) pready[1] = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL timeout_latency%0d: rsp_valid=%b in cycle 18 expected 1", pass, bus.rsp_valid);
            end else begin
                exp = expQ.pop_front();
                checks++;
                if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                    errors++;
                    $display("[TB] FAIL timeout_rsp%0d: rdata=%h err=%b expected %h/%b", pass, bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
                end
            end
            expQ.delete();
        end
        pready = '1;
    endtask
`else
    task automatic test_no_timeout();
        logic stuck;
        stuck    = 1'b1;
        pready   = 2'b01;
        slvData1 = 32'h0BAD_F00D;
        applyStimulus(32'h0000_1000, 32'h0, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus.PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0) stuck = 1'b0;
        end
        checks++;
        if (stuck !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_timeout_wait: left ACCESS without PREADY, got %b expected 1", stuck);
        end
        pready = '1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL no_timeout_latency: rsp_valid=%b expected 1", bus.rsp_valid);
        end else begin
            exp = expQ.pop_front();
            checks++;
            if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                errors++;
                $display("[TB] FAIL no_timeout_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
            end
        end
        expQ.delete();
    endtask
`endif

    task automatic test_reset_mid_access();
        logic sawRsp;
        logic done;
        pready   = 2'b10;
        slvData0 = 32'h1357_2468;
        applyStimulus(32'h0000_000C, 32'h0, 1'b0, 32'h1357_2468, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE} !== {2'b01, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rst_pre_access: PSEL=%b PENABLE=%b expected 01/1", bus.PSEL, bus.PENABLE);
        end
        #2 n_rst = 1'b0;
        #1;
        expQ.delete();
        checks++;
        if ({bus.req_ready, bus.PADDR, bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !==
            {1'b1, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rst_async: ready=%b PADDR=%h PSEL=%b PENABLE=%b rsp_valid=%b expected 1/0/00/0/0",
                     bus.req_ready, bus.PADDR, bus.PSEL, bus.PENABLE, bus.rsp_valid);
        end
        sawRsp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) sawRsp = 1'b1;
        end
        checks++;
        if (sawRsp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_no_rsp: rsp_valid seen during reset, got %b expected 0", sawRsp);
        end
        n_rst  = 1'b1;
        pready = '1;
        expQ.push_back('{rdata: 32'h1357_2468, err: 1'b0});
        @(negedge clk);
        bus.req = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 6 && !done; c++) begin
            if (bus.rsp_valid === 1'b1) begin
                done = 1'b1;
                exp  = expQ.pop_front();
                checks++;
                if ({bus.rsp_rdata, bus.rsp_err} !== {exp.rdata, exp.err}) begin
                    errors++;
                    $display("[TB] FAIL rst_recover_rsp: rdata=%h err=%b expected %h/%b", bus.rsp_rdata, bus.rsp_err, exp.rdata, exp.err);
                end
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_recover_timeout: response seen=%b expected 1", done);
        end
    endtask

    initial begin
        bus.req       = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_write = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_decode_error();
        test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
